// File: rtl/abr_prim_rr_arb.sv
// abr_prim_rr_arb: round-robin arbiter that forwards one payload per transfer.
// Each cycle the arbiter selects one active requester and presents its
// payload downstream. A transfer completes when valid_o && ready_i.
// The search for an active requester starts at ptr and wraps circularly.
// Optional macro ABR_RR_ARB_LOCK_EN turns on grant locking. With locking on,
// a presented winner stays fixed until its transfer completes. With the macro
// undefined, the winner is re-evaluated every cycle.
// Optional macro ABR_INC_ASSERT enables embedded protocol assertions.
//
// Handshake: valid_o/data_o/idx_o are offered downstream; a transfer happens in
// exactly the cycle where valid_o && ready_i, and gnt_o pulses one-hot in that
// same cycle to tell the winning requester its payload was taken. A requester
// keeps req_i and its payload stable until it sees its gnt_o bit.
module abr_prim_rr_arb #(
    parameter int N  = 4,
    parameter int DW = 32,
    localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [N-1:0]    req_i,
    input  logic [N*DW-1:0] data_i,
    output logic [N-1:0]    gnt_o,
    output logic            valid_o,
    output logic [DW-1:0]   data_o,
    output logic [IdxW-1:0] idx_o,
    input  logic            ready_i
);

    // N expressed in the widened index arithmetic used for wrap-around
    localparam logic [IdxW:0] NW = (IdxW+1)'(N);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] lidx_q, lidx_d;

    logic [N-1:0]    rot;
    logic            search_hit;
    logic [IdxW:0]   search_off;
    logic [IdxW:0]   search_sum;
    logic [IdxW-1:0] search_idx;
    logic            lock_req;
    logic [IdxW-1:0] win;
    logic            arb_valid;
    logic [DW-1:0]   win_data;
    logic            hs;
    logic [IdxW-1:0] win_next;

    // requests rotated so that bit 0 is the requester at ptr
    assign rot = N'({req_i, req_i} >> ptr_q);

    // first active requester at or after ptr, mapped back to an absolute index
    always_comb begin
        search_hit = 1'b0;
        search_off = '0;
        for (int k = 0; k < N; k++) begin
            if (!search_hit && rot[k]) begin
                search_hit = 1'b1;
                search_off = (IdxW+1)'(k);
            end
        end
        search_sum = {1'b0, ptr_q} + search_off;
        if (search_sum >= NW) begin
            search_sum = search_sum - NW;
        end
        search_idx = search_sum[IdxW-1:0];
    end

    // request level of the locked requester
    always_comb begin
        lock_req = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (lidx_q == IdxW'(i)) begin
                lock_req = req_i[i];
            end
        end
    end

    assign win       = (state_q == LOCKED) ? lidx_q : search_idx;
    assign arb_valid = (state_q == LOCKED) ? lock_req : (|req_i);

    // payload of the current winner
    always_comb begin
        win_data = '0;
        for (int i = 0; i < N; i++) begin
            if (win == IdxW'(i)) begin
                win_data = data_i[i*DW +: DW];
            end
        end
    end

    // outputs, forced quiet while reset is asserted
    always_comb begin
        valid_o = arb_valid && !rst_i;
        idx_o   = valid_o ? win : '0;
        data_o  = valid_o ? win_data : '0;
        gnt_o   = '0;
        for (int i = 0; i < N; i++) begin
            gnt_o[i] = valid_o && ready_i && (win == IdxW'(i));
        end
    end

    assign hs       = valid_o && ready_i;
    assign win_next = ({1'b0, win} == (NW - 1'b1)) ? '0 : (win + 1'b1);

    // next-state: pointer advance on transfer, optional lock entry/exit
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        lidx_d  = lidx_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    ptr_d = win_next;
                end
`ifdef ABR_RR_ARB_LOCK_EN
                else if (valid_o) begin
                    state_d = LOCKED;
                    lidx_d  = win;
                end
`endif
            end
            LOCKED: begin
                if (hs) begin
                    ptr_d   = win_next;
                    state_d = IDLE;
                end else if (!lock_req) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            lidx_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            lidx_q  <= lidx_d;
        end
    end

`ifdef ABR_INC_ASSERT
    a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(gnt_o));
`ifdef ABR_RR_ARB_LOCK_EN
    a_lock_stable : assert property (@(posedge clk_i) disable iff (rst_i)
        (valid_o && !ready_i) |=> (idx_o == $past(idx_o)));
`endif
`endif

endmodule

// File: tb/tb_abr_prim_rr_arb.sv
// Bench for abr_prim_rr_arb: directed scenarios plus randomized traffic checked
// against a request-level round-robin model. Also covers an N=1 instance.
module tb_abr_prim_rr_arb;

    localparam int N  = 4;
    localparam int DW = 32;
`ifdef ABR_RR_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT (N=4) ----------------
    logic [N-1:0]    req = '0;
    logic [N*DW-1:0] data;
    logic            ready = 1'b0;
    logic [N-1:0]    gnt;
    logic            valid;
    logic [DW-1:0]   data_o;
    logic [1:0]      idx;
    logic [DW-1:0]   dv [N];

    always_comb begin
        for (int i = 0; i < N; i++) data[i*DW +: DW] = dv[i];
    end

    abr_prim_rr_arb #(.N(N), .DW(DW)) u_dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data),
        .gnt_o(gnt), .valid_o(valid), .data_o(data_o), .idx_o(idx),
        .ready_i(ready)
    );

    // ---------------- DUT (N=1) ----------------
    logic       req1 = 1'b0;
    logic [7:0] data1 = 8'h00;
    logic       ready1 = 1'b0;
    logic       gnt1;
    logic       valid1;
    logic [7:0] data_o1;
    logic [0:0] idx1;

    abr_prim_rr_arb #(.N(1), .DW(8)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .req_i(req1), .data_i(data1),
        .gnt_o(gnt1), .valid_o(valid1), .data_o(data_o1), .idx_o(idx1),
        .ready_i(ready1)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Request-level view: a pointer, and (with locking) a remembered winner.
    int m_ptr    = 0;
    bit m_locked = 1'b0;
    int m_lidx   = 0;

    function automatic bit bit_of(input logic [N-1:0] r, input int i);
        return ((r >> i) & 1) != 0;
    endfunction

    task automatic model_eval(input logic [N-1:0] r, output bit v, output int w);
        bit found;
        w = 0;
        if (m_locked) begin
            v = bit_of(r, m_lidx);
            w = m_lidx;
        end else begin
            v = (r != 0);
            found = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (!found && bit_of(r, (m_ptr + k) % N)) begin
                    found = 1'b1;
                    w = (m_ptr + k) % N;
                end
            end
        end
    endtask

    task automatic model_update(input logic [N-1:0] r, input bit rdy, input bit v, input int w);
        if (v && rdy) begin
            m_ptr    = (w + 1) % N;
            m_locked = 1'b0;
        end else if (m_locked && !bit_of(r, m_lidx)) begin
            m_locked = 1'b0;
        end else if (!m_locked && v && LOCK_EN) begin
            m_locked = 1'b1;
            m_lidx   = w;
        end
    endtask

    // ---------------- driver tasks ----------------
    logic [N-1:0] last_gnt;
    logic [1:0]   last_idx;
    logic         last_valid;

    // one cycle: drive, compare against the model mid-cycle, advance the model
    task automatic step(input logic [N-1:0] r, input bit rdy, input string tag);
        bit v;
        int w;
        logic [N-1:0]  e_gnt;
        logic [DW-1:0] e_data;
        req   = r;
        ready = rdy;
        @(negedge clk);
        model_eval(r, v, w);
        e_gnt  = (v && rdy) ? N'(1 << w) : '0;
        e_data = v ? dv[w] : '0;
        chk({tag, "_valid"}, valid, v);
        chk({tag, "_idx"}, idx, v ? w : 0);
        chk({tag, "_gnt"}, gnt, e_gnt);
        chk({tag, "_data"}, data_o, e_data);
        last_gnt   = gnt;
        last_idx   = idx;
        last_valid = valid;
        @(posedge clk);
        model_update(r, rdy, v, w);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        req    = '1;
        ready  = 1'b1;
        req1   = 1'b1;
        ready1 = 1'b1;
        @(negedge clk);
        chk("rst_valid", valid, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_idx", idx, 0);
        chk("rst_data", data_o, 0);
        chk("rst1_valid", valid1, 0);
        chk("rst1_gnt", gnt1, 0);
        chk("rst1_data", data_o1, 0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        req      = '0;
        req1     = 1'b0;
        ready1   = 1'b0;
        m_ptr    = 0;
        m_locked = 1'b0;
        m_lidx   = 0;
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] seq_gnt [5];
    logic [1:0] seq_idx [5];
    logic [N-1:0] pend;
    int wait_hs [N];
    bit rdy_r;

    initial begin
        for (int i = 0; i < N; i++) dv[i] = 32'h1000_0000 * (i + 1) + 32'h55;
        seq_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        seq_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

        do_reset();

        // full contention with ready held high rotates through all requesters
        for (int c = 0; c < 5; c++) begin
            step(4'b1111, 1'b1, "rr");
            chk("rr_seq_gnt", last_gnt, seq_gnt[c]);
            chk("rr_seq_idx", last_idx, seq_idx[c]);
        end

        // wrap-around search: move ptr to 3, then requests 0 and 2
        do_reset();
        step(4'b0100, 1'b1, "wr_setup");
        step(4'b0101, 1'b1, "wr");
        chk("wrap_gnt", last_gnt, 4'b0001);
        step(4'b0101, 1'b1, "wr2");
        chk("wrap_next_idx", last_idx, 2'd2);

        // lock behaviour (or its absence) with a stalled consumer
        do_reset();
        if (LOCK_EN) begin
            step(4'b0001, 1'b0, "lk0");
            chk("lock_idx0", last_idx, 2'd0);
            for (int c = 0; c < 3; c++) begin
                step(4'b1111, 1'b0, "lk");
                chk("lock_hold_idx", last_idx, 2'd0);
                chk("lock_hold_gnt", last_gnt, 4'b0000);
            end
            step(4'b1111, 1'b1, "lk_rdy");
            chk("lock_rel_gnt", last_gnt, 4'b0001);
            step(4'b1110, 1'b0, "lk_next");
            chk("lock_next_idx", last_idx, 2'd1);
        end else begin
            step(4'b0001, 1'b1, "nl_setup");
            step(4'b0001, 1'b0, "nl0");
            chk("nolock_idx0", last_idx, 2'd0);
            for (int c = 0; c < 3; c++) begin
                step(4'b1111, 1'b0, "nl");
                chk("nolock_idx", last_idx, 2'd1);
                chk("nolock_gnt", last_gnt, 4'b0000);
            end
            step(4'b1111, 1'b1, "nl_rdy");
            chk("nolock_rel_gnt", last_gnt, 4'b0010);
        end

        // reset in the middle of a stalled transfer on requester 2
        do_reset();
        step(4'b0100, 1'b0, "ml");
        chk("midlock_idx", last_idx, 2'd2);
        step(4'b0100, 1'b0, "ml2");
        do_reset();
        step(4'b1111, 1'b0, "post_rst");
        chk("post_rst_idx", last_idx, 2'd0);

        // single-requester instance behaves as a pass-through
        req1   = 1'b1;
        data1  = 8'hA5;
        ready1 = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("n1_valid", valid1, 1);
            chk("n1_data", data_o1, 8'hA5);
            chk("n1_idx", idx1, 0);
            chk("n1_gnt", gnt1, 1);
            @(posedge clk);
            #1;
        end
        ready1 = 1'b0;
        @(negedge clk);
        chk("n1_stall_gnt", gnt1, 0);
        chk("n1_stall_valid", valid1, 1);
        @(posedge clk);
        #1;
        req1 = 1'b0;

        // randomized traffic; requests persist until granted
        do_reset();
        pend = '0;
        for (int i = 0; i < N; i++) wait_hs[i] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    dv[i]   = $urandom;
                end
            end
            rdy_r = ($urandom_range(0, 3) != 0);
            step(pend, rdy_r, "rnd");
            for (int i = 0; i < N; i++) begin
                if (pend[i] && last_gnt != 0) wait_hs[i]++;
                if (last_gnt[i]) begin
                    chk("starve_bound", (wait_hs[i] <= N), 1);
                    wait_hs[i] = 0;
                    pend[i]    = 1'b0;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
